// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN calculator stack sequencer.
package rpn_pkg;

   // Sequencer states; one pass through the binary-op path is LD_B..PUSH_R.
   typedef enum logic [3:0] {
      S_IDLE,
      S_PUSH_SW,
      S_LD_B,
      S_WAIT_B,
      S_LD_A,
      S_WAIT_A,
      S_EXEC,
      S_PUSH_R,
      S_RELEASE
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_OVF  = 2'd1,
      ERR_UNF  = 2'd2,
      ERR_ILL  = 2'd3
   } err_t;

   typedef enum logic [1:0] {
      OP_0 = 2'd0,
      OP_1 = 2'd1,
      OP_2 = 2'd2,
      OP_3 = 2'd3
   } alu_op_t;

   // Button bit positions: [0] pushes the switches, [4:1] select the binary op.
   localparam int           BTN_PUSH      = 0;
   localparam int           BTN_OP_LO     = 1;
   localparam int           BTN_OP_HI     = 4;
   localparam logic [4:0]   BTN_PUSH_ONLY = 5'b00001;

   // True when exactly one bit of the op-button field is set.
   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Maps a one-hot op-button field to its ALU op code (bit index).
   function automatic alu_op_t op_index(input logic [3:0] v);
      alu_op_t op;
      op = OP_0;
      case (v)
         4'b0010: op = OP_1;
         4'b0100: op = OP_2;
         4'b1000: op = OP_3;
         default: op = OP_0;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rpn_depth_ctr.sv
// Stack occupancy counter: moves by one word per cycle, flags full and fewer-than-two.
module rpn_depth_ctr #(
   parameter int DEPTH   = 16,
   parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               dec,
   output logic [DEPTH_W-1:0] depth,
   output logic               full,
   output logic               lt2
);

   logic [DEPTH_W-1:0] depth_q;
   logic [DEPTH_W-1:0] depth_d;

   // Next occupancy; simultaneous inc and dec cancel.
   always_comb begin
      // NOTE: default assignment first so every path assigns depth_d and no latch is inferred.
      depth_d = depth_q;
      if (inc && !dec)
         depth_d = depth_q + DEPTH_W'(1);
      else if (dec && !inc)
         depth_d = depth_q - DEPTH_W'(1);
   end

   // Occupancy register, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!rst)
         depth_q <= '0;
      else
         depth_q <= depth_d;
   end

   assign depth = depth_q;
   assign full  = (depth_q == DEPTH_W'(DEPTH));
   assign lt2   = (depth_q <  DEPTH_W'(2));

endmodule

// File: rtl/rpn_stack_sequencer.sv
// Decodes button commands and sequences every push/pop between the stack memory and the ALU.
module rpn_stack_sequencer
   import rpn_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SW_W    = 16,
   parameter int DEPTH   = 16,
   parameter int DEPTH_W = $clog2(DEPTH + 1),
   parameter int ALU_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         btns,
   input  logic [SW_W-1:0]    switches,
   input  logic [DATA_W-1:0]  stk_rd_data,
   input  logic [DATA_W-1:0]  alu_out,
   output logic               stk_push,
   output logic               stk_pop,
   output logic [DATA_W-1:0]  stk_wr_data,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [1:0]         alu_op,
   output logic               busy,
   output logic [1:0]         err,
   output logic [DEPTH_W-1:0] depth
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_t            state_q,  state_d;
   logic              armed_q,  armed_d;
   err_t              err_q,    err_d;
   alu_op_t           alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_a_q,  alu_a_d;
   logic [DATA_W-1:0] alu_b_q,  alu_b_d;
   logic [SW_W-1:0]   sw_q,     sw_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;

   logic accept;
   logic full;
   logic lt2;

   // Only one command per press: IDLE, armed, and some button down.
   assign accept = (state_q == S_IDLE) && armed_q && (btns != 5'd0);

   // Next-state and datapath-latch logic for the whole sequence.
   always_comb begin
      state_d  = state_q;
      armed_d  = armed_q;
      err_d    = err_q;
      alu_op_d = alu_op_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      sw_d     = sw_q;
      cnt_d    = cnt_q;

      if (btns == 5'd0)
         armed_d = 1'b1;
      if (accept)
         armed_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (btns == BTN_PUSH_ONLY) begin
                  if (full) begin
                     err_d   = ERR_OVF;
                     state_d = S_RELEASE;
                  end else begin
                     err_d   = ERR_NONE;
                     sw_d    = switches;
                     state_d = S_PUSH_SW;
                  end
               end else if (!btns[BTN_PUSH] && is_onehot4(btns[BTN_OP_HI:BTN_OP_LO])) begin
                  if (lt2) begin
                     err_d   = ERR_UNF;
                     state_d = S_RELEASE;
                  end else begin
                     err_d    = ERR_NONE;
                     alu_op_d = op_index(btns[BTN_OP_HI:BTN_OP_LO]);
                     state_d  = S_LD_B;
                  end
               end else begin
                  err_d   = ERR_ILL;
                  state_d = S_RELEASE;
               end
            end
         end
         S_PUSH_SW: state_d = S_RELEASE;
         S_LD_B: begin
            alu_b_d = stk_rd_data;
            state_d = S_WAIT_B;
         end
         S_WAIT_B: state_d = S_LD_A;
         S_LD_A: begin
            alu_a_d = stk_rd_data;
            state_d = S_WAIT_A;
         end
         S_WAIT_A: begin
            cnt_d   = CNT_W'(ALU_LAT - 1);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (cnt_q == '0)
               state_d = S_PUSH_R;
            else
               cnt_d = cnt_q - CNT_W'(1);
         end
         S_PUSH_R: state_d = S_RELEASE;
         S_RELEASE: begin
            if (btns == 5'd0)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM and latched-operand registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         armed_q  <= 1'b1;
         err_q    <= ERR_NONE;
         alu_op_q <= OP_0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         sw_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         armed_q  <= armed_d;
         err_q    <= err_d;
         alu_op_q <= alu_op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         sw_q     <= sw_d;
         cnt_q    <= cnt_d;
      end
   end

   // Moore decode of the stack strobes and write data from the state register.
   always_comb begin
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_wr_data = '0;
      case (state_q)
         S_PUSH_SW: begin
            stk_push    = 1'b1;
            stk_wr_data = DATA_W'(sw_q);
         end
         S_PUSH_R: begin
            stk_push    = 1'b1;
            stk_wr_data = alu_out;
         end
         S_LD_B, S_LD_A: stk_pop = 1'b1;
         default: ;
      endcase
   end

   rpn_depth_ctr #(
      .DEPTH   (DEPTH),
      .DEPTH_W (DEPTH_W)
   ) u_depth_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (state_q == S_PUSH_SW),
      .dec   (state_q == S_PUSH_R),
      .depth (depth),
      .full  (full),
      .lt2   (lt2)
   );

   assign busy   = (state_q != S_IDLE);
   assign err    = err_q;
   assign alu_op = alu_op_q;
   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;

endmodule
